// File: rtl/branch_pc_unit.sv
// Program-counter owner and conditional-branch sequencer. It pulses the condition
// flip-flop latch, samples CON one cycle later, then commits PC+sext(C) or PC.
module branch_pc_unit #(
  parameter int                  PC_WIDTH = 32,
  parameter int                  C_WIDTH  = 19,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                br_start_i,
  input  logic [C_WIDTH-1:0]  br_offset_i,
  input  logic                con_flag_i,
  output logic                con_latch_o,
  input  logic                pc_inc_i,
  input  logic                jump_valid_i,
  input  logic [PC_WIDTH-1:0] jump_target_i,
  output logic [PC_WIDTH-1:0] pc_out_o,
  output logic                busy_o,
  output logic                br_done_o,
  output logic                br_taken_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    SAMPLE = 2'd2,
    COMMIT = 2'd3
  } state_e;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] offset_q, offset_d;
  logic                taken_q, taken_d;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      offset_q <= '0;
      taken_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      offset_q <= offset_d;
      taken_q  <= taken_d;
    end
  end

  // Only the highest-priority IDLE request is acted on; the rest are dropped.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    offset_d = offset_q;
    taken_d  = taken_q;
    case (state_q)
      IDLE: begin
        if (jump_valid_i) begin
          pc_d = jump_target_i;
        end else if (br_start_i) begin
          offset_d = {{(PC_WIDTH-C_WIDTH){br_offset_i[C_WIDTH-1]}}, br_offset_i};
          state_d  = EVAL;
        end else if (pc_inc_i) begin
          pc_d = pc_q + PC_ONE;
        end
      end
      EVAL: begin
        state_d = SAMPLE;
      end
      SAMPLE: begin
        taken_d = con_flag_i;
        state_d = COMMIT;
      end
      COMMIT: begin
        if (taken_q) begin
          pc_d = pc_q + offset_q;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // taken_q updates on entry to COMMIT, so it changes only as br_done rises and then holds.
  assign con_latch_o = (state_q == EVAL);
  assign busy_o      = (state_q != IDLE);
  assign br_done_o   = (state_q == COMMIT);
  assign br_taken_o  = taken_q;
  assign pc_out_o    = pc_q;

endmodule
